// File: rtl/ql_pkg.sv
// ql_pkg: shared state/owner types and default sizing for the QL RAM arbiter.
package ql_pkg;

    localparam int QL_ADDR_W     = 24;
    localparam int QL_VID_PERIOD = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_PENALTY,
        ST_DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_MDV  = 2'd2,
        OWN_CPU  = 2'd3
    } arb_owner_t;

endpackage

// File: rtl/ql_slot_counter.sv
// ql_slot_counter: modulo-VID_PERIOD slot counter advanced by ce_bus_p; vid_slot marks slot 0.
module ql_slot_counter
    import ql_pkg::*;
#(
    parameter int VID_PERIOD = QL_VID_PERIOD
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic ce_bus_p,
    output logic vid_slot
);

    localparam int CW = $clog2(VID_PERIOD);

    logic [CW-1:0] slot_cnt;

    always_ff @(posedge clk_sys or posedge reset)
        if (reset)
            slot_cnt <= '0;
        else if (ce_bus_p)
            slot_cnt <= (slot_cnt == CW'(VID_PERIOD - 1)) ? '0 : slot_cnt + CW'(1);

    assign vid_slot = (slot_cnt == '0);

endmodule

// File: rtl/ql_ram_arbiter.sv
// ql_ram_arbiter: slot-paced sequencer of the shared SDRAM port (video, microdrive DMA, 68008 CPU).
// Define QL_ARB_MDV_EN to arbitrate the microdrive port; otherwise it is ignored and mdv_gnt is 0.
module ql_ram_arbiter
    import ql_pkg::*;
#(
    parameter int ADDR_W     = QL_ADDR_W,
    parameter int VID_PERIOD = QL_VID_PERIOD
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              enable,
    input  logic              ce_bus_p,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    input  logic              mdv_req,
    input  logic              mdv_we,
    input  logic [ADDR_W-1:0] mdv_addr,
    output logic              mdv_gnt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_uds,
    input  logic              cpu_lds,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_dtack,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_oe,
    output logic              sdram_wr,
    output logic [1:0]        sdram_ds,
    input  logic              sdram_ack,
    output logic [1:0]        owner
);

    arb_state_t state, state_nxt;
    arb_owner_t own_q, own_sel;
    logic       vid_slot, mdv_ok, we_q, wide_q, grant;

`ifdef QL_ARB_MDV_EN
    assign mdv_ok  = mdv_req;
    assign mdv_gnt = (state == ST_DONE) && (own_q == OWN_MDV);
`else
    logic mdv_unused;
    assign mdv_unused = ^{mdv_req, mdv_we, mdv_addr};
    assign mdv_ok     = 1'b0;
    assign mdv_gnt    = 1'b0;
`endif

    ql_slot_counter #(.VID_PERIOD(VID_PERIOD)) u_slot (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce_bus_p (ce_bus_p),
        .vid_slot (vid_slot)
    );

    assign own_sel = (vid_req && vid_slot) ? OWN_VID :
                     mdv_ok                ? OWN_MDV :
                     cpu_req               ? OWN_CPU : OWN_NONE;

    always_ff @(posedge clk_sys or posedge reset)
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (ce_bus_p && own_sel != OWN_NONE) state_nxt = ST_ISSUE;
            ST_ISSUE:    state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: if (sdram_ack) state_nxt = (own_q == OWN_CPU && enable && wide_q) ? ST_PENALTY : ST_DONE;
            ST_PENALTY:  if (ce_bus_p) state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign grant = (state == ST_IDLE) && (state_nxt == ST_ISSUE);

    // Command fields are captured at grant so requesters may change them once served.
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            own_q      <= OWN_NONE;
            sdram_addr <= '0;
            sdram_ds   <= '0;
            we_q       <= 1'b0;
            wide_q     <= 1'b0;
        end else if (grant) begin
            own_q      <= own_sel;
            sdram_addr <= (own_sel == OWN_VID) ? vid_addr : (own_sel == OWN_MDV) ? mdv_addr : cpu_addr;
            sdram_ds   <= (own_sel == OWN_CPU) ? {cpu_uds, cpu_lds} : 2'b11;
            we_q       <= (own_sel == OWN_MDV) ? mdv_we : (own_sel == OWN_CPU) && cpu_we;
            wide_q     <= cpu_uds && cpu_lds;
        end else if (state == ST_DONE) begin
            own_q      <= OWN_NONE;
        end

    assign sdram_oe  = (state == ST_ISSUE) && !we_q;
    assign sdram_wr  = (state == ST_ISSUE) && we_q;
    assign owner     = own_q;
    assign vid_gnt   = (state == ST_DONE) && (own_q == OWN_VID);
    assign cpu_dtack = (state == ST_DONE) && (own_q == OWN_CPU) && cpu_req;

endmodule

// File: doc/ql_ram_arbiter.md
# ql_ram_arbiter

Sequences the single SDRAM port shared by video fetch, microdrive DMA and the 68008 CPU. Slots are paced by `ce_bus_p`. Video steals slots at a fixed cadence, as on the original QL. CPU 16-bit accesses pay an extra-slot penalty so that CPU RAM timing matches the 8-bit original. The block sits between the requesters and the SDRAM controller and produces the CPU's RAM DTACK.

## Interface
- `ADDR_W`, 24, SDRAM byte-address width.
- `VID_PERIOD`, 2, video may own one slot in every `VID_PERIOD` slots (≥2).
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: QL timing emulation on; when 0, no 16-bit penalty.
- `ce_bus_p` in 1: one-cycle slot-start strobe.
- `vid_req` in 1, `vid_addr` in ADDR_W, `vid_gnt` out 1: video read port.
- `mdv_req` in 1, `mdv_we` in 1, `mdv_addr` in ADDR_W, `mdv_gnt` out 1: microdrive DMA port.
- `cpu_req` in 1, `cpu_we` in 1, `cpu_uds` in 1, `cpu_lds` in 1, `cpu_addr` in ADDR_W: CPU port.
- `cpu_dtack` out 1: CPU access complete.
- `sdram_addr` out ADDR_W, `sdram_oe` out 1, `sdram_wr` out 1, `sdram_ds` out 2 ({uds,lds}): command to the SDRAM controller.
- `sdram_ack` in 1: one-cycle pulse when the SDRAM controller completes a read or write.
- `owner` out 2: 0 none, 1 video, 2 mdv, 3 cpu.

## Operation
- Reset values: every output is 0, the state is IDLE, and `slot_cnt` is 0.
- `slot_cnt` increments on every `ce_bus_p`, wraps at VID_PERIOD-1→0, and counts in all states.
- States: IDLE, ISSUE, WAIT_ACK, PENALTY, DONE.
- IDLE, on `ce_bus_p`, selects an owner in priority order:
  - video, if `vid_req` and `slot_cnt`==0 (value before increment);
  - else mdv, if `mdv_req`;
  - else cpu, if `cpu_req`.
  - With no requester, the state stays IDLE.
  - The owner's address, we and ds are latched into `sdram_*`. Video and mdv use ds=2'b11. Video we=0.
- ISSUE: `sdram_oe` (read) or `sdram_wr` (write) high for exactly one cycle, then → WAIT_ACK.
- WAIT_ACK: holds until `sdram_ack`.
  - If owner is cpu, `enable`=1 and `cpu_uds`&`cpu_lds` (latched at grant) → PENALTY.
  - Otherwise → DONE.
- PENALTY: waits for the next `ce_bus_p`, then → DONE.
- DONE: one-cycle pulse on the owner's `vid_gnt`, `mdv_gnt` or `cpu_dtack`, then → IDLE. `owner` is cleared in IDLE.
- `cpu_dtack` is suppressed if `cpu_req` is low in DONE (CPU aborted). The SDRAM access still completes.
- Requesters hold req, addr and we stable until their gnt/dtack pulse. The arbiter cannot re-grant before the next `ce_bus_p`.
- `ce_bus_p` in any state other than IDLE/PENALTY only advances `slot_cnt`.
- An `sdram_ack` outside WAIT_ACK is ignored. This covers a stale ack after reset.
- Asynchronous reset mid-access drops everything immediately. No dtack or gnt is issued for the aborted access.

## Timing
- `ce_bus_p` at cycle N in IDLE gives ISSUE at N+1, with `sdram_oe`/`sdram_wr` high during N+1 only and `owner` valid from N+1.
- `sdram_ack` sampled at cycle A with no penalty gives DONE, and the gnt/dtack pulse, at A+1.
- With the penalty, DONE falls in the cycle after the first `ce_bus_p` strictly after A.
- Minimum IDLE→IDLE is 4 cycles plus the SDRAM latency.
- `ce_bus_p` coincident with `sdram_ack` in WAIT_ACK does not satisfy PENALTY; the block waits for a later strobe.
- `enable` is sampled at the cycle `sdram_ack` arrives.

## Configuration
- `QL_ARB_MDV_EN` defined: the microdrive port is arbitrated as above.
- `QL_ARB_MDV_EN` undefined:
  - `mdv_req`, `mdv_we` and `mdv_addr` are ignored;
  - `mdv_gnt` is tied 0;
  - `owner` never takes value 2;
  - priority is video then cpu.

## Structure
- Shared package `ql_pkg` holds:
  - the state enum `arb_state_t`;
  - the owner encoding `arb_owner_t` (NONE/VID/MDV/CPU);
  - the default constants for ADDR_W and VID_PERIOD.
- One sub-module, `ql_slot_counter`: modulo-VID_PERIOD counter on `ce_bus_p` with async reset, output `vid_slot` (`slot_cnt`==0).

## Test plan
- Only `cpu_req` active, 8-bit read (uds=1, lds=0), `sdram_ack` 3 cycles after ISSUE → `cpu_dtack` pulse exactly 1 cycle after ack; `sdram_ds`=2'b10.
- CPU 16-bit write with `enable`=1, `ce_bus_p` every 8 cycles → dtack in the cycle after the next strobe following ack. The same access with `enable`=0 → dtack at ack+1.
- `vid_req` and `cpu_req` both held, VID_PERIOD=2 → owners alternate video/cpu on successive eligible slots; video is never granted when `slot_cnt`=1.
- `mdv_req` and `cpu_req` together at a slot with `slot_cnt`=1 → mdv granted first. With `QL_ARB_MDV_EN` undefined → cpu granted and `mdv_gnt` stays 0.
- `reset` asserted during WAIT_ACK, then a late `sdram_ack` after release → all outputs 0, no dtack or gnt, state IDLE.
- `cpu_req` dropped during WAIT_ACK → the access completes and `cpu_dtack` stays 0.
